// File: rtl/redmule_pkg.sv
// Shared RedMulE types and constants for the TCDM responder in its default configuration.
package redmule_pkg;

    localparam int unsigned TCDM_DW        = 288;
    localparam int unsigned TCDM_AW        = 32;
    localparam int unsigned TCDM_DEPTH     = 256;
    localparam int unsigned TCDM_LATENCY   = 1;
    localparam int unsigned TCDM_RSP_DEPTH = 4;

    // Pipeline stages plus FIFO slots: every granted read always has a place to land.
    localparam int unsigned RSP_CREDITS = TCDM_LATENCY + TCDM_RSP_DEPTH;

    typedef struct packed {
        logic [TCDM_DW-1:0] data;
    } tcdm_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 interface (optional fall-through).
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

    dtype                  mem_q [FifoDepth];
    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  do_push, do_pop, bypass;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(FifoDepth));
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];

    // In fall-through mode a push and pop on an empty FIFO pass straight through.
    assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
    assign do_push = push_i && !full_o && !bypass;
    assign do_pop  = pop_i && (cnt_q != '0);
    assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : wr_ptr_q + ADDR_DEPTH'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : rd_ptr_q + ADDR_DEPTH'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (ADDR_DEPTH+1)'(1);
            2'b01:   cnt_d = cnt_q - (ADDR_DEPTH+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/redmule_tcdm_responder.sv
// Single-ported byte-enabled TCDM target answering RedMulE streamer requests with
// fixed-latency in-order read responses and credit-based grant throttling.
module redmule_tcdm_responder
    import redmule_pkg::*;
#(
    parameter int unsigned DW        = TCDM_DW,
    parameter int unsigned AW        = TCDM_AW,
    parameter int unsigned DEPTH     = TCDM_DEPTH,
    parameter int unsigned LATENCY   = TCDM_LATENCY,
    parameter int unsigned RSP_DEPTH = TCDM_RSP_DEPTH
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    clear_i,
    input  logic                                    enable_i,
    input  logic                                    req_i,
    output logic                                    gnt_o,
    input  logic [AW-1:0]                           add_i,
    input  logic                                    wen_i,
    input  logic [DW/8-1:0]                         be_i,
    input  logic [DW-1:0]                           data_i,
    output logic                                    r_valid_o,
    input  logic                                    r_ready_i,
    output logic [DW-1:0]                           r_data_o,
    output logic [$clog2(LATENCY+RSP_DEPTH+1)-1:0]  outstanding_o,
    output logic [31:0]                             stall_cnt_o
);

    localparam int unsigned NB      = DW / 8;
    localparam int unsigned OFS     = $clog2(NB);
    localparam int unsigned IW      = $clog2(DEPTH);
    localparam int unsigned OW      = $clog2(LATENCY + RSP_DEPTH + 1);
    localparam int unsigned Credits = LATENCY + RSP_DEPTH;
    localparam int unsigned UsageW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DW-1:0]              mem_q [DEPTH];
    logic [IW-1:0]              idx;
    logic                       base_gnt, read_gnt, write_gnt, credit_ok;
    logic [OW-1:0]              outstanding_q, outstanding_d;
    logic [31:0]                stall_cnt_q, stall_cnt_d;

    logic [LATENCY-1:0]         pipe_valid_q;
    logic [LATENCY-1:0][DW-1:0] pipe_data_q;
    logic [LATENCY-1:0]         stage_in_valid, stage_adv;
    logic [LATENCY-1:0][DW-1:0] stage_in_data;
    logic [LATENCY:0]           stage_load;

    logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0]              fifo_data;
    logic [UsageW-1:0]          unused_usage;
    logic                       unused_add;

    // Low byte-offset bits and bits above the memory index are deliberately ignored.
    assign idx        = add_i[OFS +: IW];
    assign unused_add = ^add_i;

    // Credits cover pipeline plus FIFO occupancy, so no granted read can be dropped.
    assign credit_ok = outstanding_q < OW'(Credits);
    assign base_gnt  = rst_ni && req_i && enable_i && !clear_i;
    assign read_gnt  = base_gnt && wen_i && credit_ok;
    assign write_gnt = base_gnt && !wen_i;
    assign gnt_o     = read_gnt || write_gnt;

    always_ff @(posedge clk_i) begin
        if (write_gnt) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    // Bubble-collapsing pipeline: a stage loads when empty or when its content moves on.
    always_comb begin
        stage_adv            = '0;
        stage_load           = '0;
        stage_in_valid       = '0;
        stage_in_data        = '0;
        stage_load[LATENCY]  = !fifo_full;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            stage_adv[i]  = pipe_valid_q[i] && stage_load[i+1];
            stage_load[i] = !pipe_valid_q[i] || stage_adv[i];
        end
        stage_in_valid[0] = read_gnt;
        stage_in_data[0]  = mem_q[idx];
        for (int i = 1; i < LATENCY; i++) begin
            stage_in_valid[i] = stage_adv[i-1];
            stage_in_data[i]  = pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= '0;
            pipe_data_q  <= '0;
        end else if (clear_i) begin
            pipe_valid_q <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                if (stage_load[i]) begin
                    pipe_valid_q[i] <= stage_in_valid[i];
                    if (stage_in_valid[i]) begin
                        pipe_data_q[i] <= stage_in_data[i];
                    end
                end
            end
        end
    end

    assign fifo_push = stage_adv[LATENCY-1] && !clear_i;
    assign fifo_pop  = r_valid_o && r_ready_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (DW),
        .DEPTH        (RSP_DEPTH)
    ) i_rsp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (clear_i),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (unused_usage),
        .data_i     (pipe_data_q[LATENCY-1]),
        .push_i     (fifo_push),
        .data_o     (fifo_data),
        .pop_i      (fifo_pop)
    );

    assign r_valid_o = !fifo_empty;
    assign r_data_o  = fifo_empty ? '0 : fifo_data;

    always_comb begin
        outstanding_d = outstanding_q;
        stall_cnt_d   = stall_cnt_q;
        if (clear_i) begin
            outstanding_d = '0;
            stall_cnt_d   = '0;
        end else begin
            unique case ({read_gnt, fifo_pop})
                2'b10:   outstanding_d = outstanding_q + OW'(1);
                2'b01:   outstanding_d = outstanding_q - OW'(1);
                default: outstanding_d = outstanding_q;
            endcase
            if (req_i && !gnt_o && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/redmule_tcdm_responder.md
# redmule_tcdm_responder

TCDM target that answers the HCI core requests issued by the RedMulE streamer, for block-level benches and for standalone accelerator integration without the cluster interconnect. It holds a single-ported, byte-enabled word memory. Reads return in order after a fixed pipeline latency and are buffered in a response FIFO so that `r_ready` back-pressure is honoured. A credit counter withholds grant so that no response is ever dropped.

## Interface
- `DW`, 288: data width in bits; must be a multiple of 8.
- `AW`, 32: byte-address width.
- `DEPTH`, 256: memory depth in DW-bit words; power of two, ≥2.
- `LATENCY`, 1: grant-to-response pipeline stages; ≥1.
- `RSP_DEPTH`, 4: response FIFO entries; ≥1.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous flush of in-flight state.
- `enable_i` in 1: when low, no grants are issued.
- `req_i` in 1: request valid.
- `gnt_o` out 1: request accepted this cycle.
- `add_i` in AW: byte address.
- `wen_i` in 1: 1 = read, 0 = write (HCI polarity).
- `be_i` in DW/8: byte enables for writes.
- `data_i` in DW: write data.
- `r_valid_o` out 1: read response valid.
- `r_ready_i` in 1: response consumer ready.
- `r_data_o` out DW: read data.
- `outstanding_o` out $clog2(LATENCY+RSP_DEPTH+1): reads granted but not yet popped.
- `stall_cnt_o` out 32: cycles with `req_i && !gnt_o`; saturating.

## Operation
- Word index = `add_i[$clog2(DW/8) +: $clog2(DEPTH)]`. The low byte bits are ignored. Upper bits are ignored, so addresses wrap modulo DEPTH.
- Write, granted: each byte i with `be_i[i]=1` is updated in the same clock edge. Writes produce no response.
- Write grant: `req_i && enable_i && !wen_i`. Writes never consume credit.
- Read grant: `req_i && enable_i && wen_i && outstanding < LATENCY+RSP_DEPTH`. This rule is conservative: `outstanding` counts both pipeline and FIFO entries.
- Read data is sampled at the grant edge, so a read granted the cycle after a write to the same word returns the new data.
- Read data then passes through LATENCY register stages and is pushed into the response FIFO.
- `r_valid_o` = FIFO not empty. A pop occurs on `r_valid_o && r_ready_i`. `r_data_o` = FIFO head, or 0 when the FIFO is empty.
- `outstanding` update: +1 on read grant, −1 on pop. When both occur in the same cycle, the value is unchanged.
- `stall_cnt_o` increments on every `req_i && !gnt_o` cycle and saturates at 2^32−1. `clear_i` zeroes it.
- `clear_i`:
  - Empties the pipeline and the FIFO.
  - Zeroes `outstanding_o`.
  - Forces `gnt_o=0` in that cycle.
  - Memory contents are retained.
- Memory is not reset; its contents are undefined until written.

## Timing
- Reset values: `gnt_o` 0, `r_valid_o` 0, `r_data_o` 0, `outstanding_o` 0, `stall_cnt_o` 0. `gnt_o` is also forced to 0 while `rst_ni` is low.
- `gnt_o` is combinational from `req_i`, `wen_i`, `enable_i`, `clear_i` and registered credit state. It has no combinational path from `r_ready_i`.
- Read latency: a grant at edge N gives `r_valid_o` high after edge N+LATENCY, provided the FIFO is empty or is popping.
- Throughput: with `r_ready_i` held high, one read per cycle is sustained indefinitely.
- Back-pressure: with `r_ready_i` low, exactly LATENCY+RSP_DEPTH reads are granted, then `gnt_o` drops. One pop re-opens exactly one credit on the following cycle.
- Response order equals grant order.
- Reset asserted mid-operation: all in-flight responses are lost and outputs return to reset values asynchronously.

## Structure
- Shared package `redmule_pkg` receives `tcdm_rsp_t` (struct `{logic [DW-1:0] data}`) and the constant `RSP_CREDITS = LATENCY+RSP_DEPTH`.
- The response FIFO is the common_cells `fifo_v3` (FALL_THROUGH 0, DEPTH RSP_DEPTH). The FIFO push is guaranteed by the credit rule, so `full` is never observed while pushing; the bench asserts this.
- The memory is a plain array inside the block. Its storage model is a synthesis stub only; the block is bench-oriented.

## Test plan
- Write `be_i='1`, data 0xA5.. to word 3, then read word 3 with `r_ready_i=1` → `r_valid_o` exactly LATENCY cycles after the read grant, with data 0xA5.. .
- Partial write, `be_i` = byte 0 only, data 0x11 over an existing 0xA5.. → read returns 0xA5..A511.
- `r_ready_i=0`, 10 back-to-back reads, LATENCY=1, RSP_DEPTH=4:
  - Exactly 5 grants, then `gnt_o=0`.
  - `outstanding_o=5`.
  - `stall_cnt_o` counts the stalled cycles.
  - Raising `r_ready_i` drains the 5 responses in order, and grants resume.
- Address wrap: write word DEPTH+2, then read word 2 → same data. Misaligned low address bits are ignored.
- `clear_i` with 3 responses queued → `r_valid_o=0` and `outstanding_o=0` next cycle; a subsequent read still returns previously written data.
- Reset mid-burst → all outputs return to reset values; after release the first read grant succeeds with the full credit count.
